uart_cmd_decoder: RTL and testbench

- Parametrised successor to the fixed 4-bit address/data decoder that sits behind the UART receiver.
- Consumes received 9-bit frames (8 data bits plus 1 parity bit) and parses a multi-byte command protocol: one header byte, then 0..N data bytes.
- Issues write/read handshakes to a register bank of configurable width and depth, and returns read data.
- Detects address-range, timeout and overrun errors, and keeps a saturating error count for the debug interface.

---
 rtl/uart_cmd_decoder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : Parses 9-bit UART frames (8 data + 1 parity) into register-bank
//            commands. A header byte (bit7 = write, bits[6:0] = address) is
//            followed, for writes, by BYTES data bytes (MSB byte first).
//            Issues held write/read handshakes, returns read data, and
//            reports parity/range/timeout/overrun errors with a saturating
//            error count.
// Ports    : clk, rst (sync, active-low)
//            frame_valid, frame[8:0]              - received frames
//            wr_en, wr_addr, wr_data, wr_ack      - write handshake
//            rd_req, rd_addr, rd_ack, rd_data     - read handshake
//            resp_valid, resp_data                - read result
//            err_pulse, err_code, err_count, busy - status / debug
// Options  : `define UART_CMD_PARITY_CHECK_EN to enforce even parity on
//            frame[8:0]; otherwise frame[8] is ignored.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module uart_cmd_decoder #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic [8:0]        frame,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              err_pulse,
    output logic [1:0]        err_code,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int c_BYTES = (DATA_W + 7) / 8;
    localparam int c_CNT_W = $clog2(c_BYTES + 1);
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ERR_PARITY  = 2'd0;
    localparam logic [1:0] c_ERR_RANGE   = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] c_ERR_OVERRUN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic [c_TMO_W-1:0]  r_tmo, w_tmo;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic                r_oor, w_oor;
    logic [DATA_W-1:0]   r_data, w_data;
    logic                r_wr_en, w_wr_en;
    logic                r_rd_req, w_rd_req;
    logic                r_resp_valid, w_resp_valid;
    logic [DATA_W-1:0]   r_resp_data, w_resp_data;
    logic                r_err_pulse;
    logic [1:0]          r_err_code;
    logic [7:0]          r_err_count;

    logic                w_par_err;
    logic                w_hdr_oor;
    logic                w_expire;
    logic [DATA_W-1:0]   w_shifted;
    logic                w_e_tmo, w_e_ovr, w_e_par, w_e_rng;
    logic                w_err_any;
    logic [1:0]          w_err_code;

`ifdef UART_CMD_PARITY_CHECK_EN
    // Even parity across all nine bits.
    assign w_par_err = ^frame;
`else
    logic w_unused_parity_bit;
    assign w_unused_parity_bit = frame[8];
    assign w_par_err           = 1'b0;
`endif

    assign w_hdr_oor = (32'(frame[6:0]) >= 32'(NUM_REGS));

    // The counter is zero on the first cycle of a timed state, so the edge
    // that samples TIMEOUT-1 ends the TIMEOUT-th allowed cycle.
    assign w_expire  = (r_state != S_IDLE) && (r_tmo == c_TMO_W'(TIMEOUT - 1));

    // Shift in a new byte, keeping only the low DATA_W bits.
    generate
        if (DATA_W > 8) begin : g_shift_wide
            assign w_shifted = {r_data[DATA_W-9:0], frame[7:0]};
        end else begin : g_shift_narrow
            assign w_shifted = frame[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        w_state      = r_state;
        w_tmo        = r_tmo;
        w_cnt        = r_cnt;
        w_addr       = r_addr;
        w_oor        = r_oor;
        w_data       = r_data;
        w_wr_en      = r_wr_en;
        w_rd_req     = r_rd_req;
        w_resp_valid = 1'b0;
        w_resp_data  = r_resp_data;
        w_e_tmo      = 1'b0;
        w_e_ovr      = 1'b0;
        w_e_par      = 1'b0;
        w_e_rng      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tmo = '0;
                if (frame_valid) begin
                    if (w_par_err) begin
                        w_e_par = 1'b1;
                    end else if (frame[7]) begin
                        // Range is checked only after all data bytes arrive.
                        w_state = S_DATA;
                        w_cnt   = c_CNT_W'(c_BYTES);
                        w_addr  = frame[ADDR_W-1:0];
                        w_oor   = w_hdr_oor;
                    end else if (w_hdr_oor) begin
                        w_e_rng = 1'b1;
                    end else begin
                        w_state  = S_READ;
                        w_addr   = frame[ADDR_W-1:0];
                        w_rd_req = 1'b1;
                    end
                end
            end

            S_DATA: begin
                w_tmo = r_tmo + c_TMO_W'(1);
                if (w_expire) begin
                    // A frame landing on the expiry cycle is discarded.
                    w_e_tmo = 1'b1;
                    w_state = S_IDLE;
                    w_tmo   = '0;
                end else if (frame_valid) begin
                    w_tmo = '0;
                    if (w_par_err) begin
                        w_e_par = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_data = w_shifted;
                        w_cnt  = r_cnt - c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(1)) begin
                            if (r_oor) begin
                                w_e_rng = 1'b1;
                                w_state = S_IDLE;
                            end else begin
                                w_state = S_WRITE;
                                w_wr_en = 1'b1;
                            end
                        end
                    end
                end
            end

            S_WRITE: begin
                w_tmo   = r_tmo + c_TMO_W'(1);
                w_e_ovr = frame_valid;
                // An ack on the expiry cycle still completes the write.
                if (wr_ack) begin
                    w_wr_en = 1'b0;
                    w_state = S_IDLE;
                    w_tmo   = '0;
                end else if (w_expire) begin
                    w_e_tmo = 1'b1;
                    w_wr_en = 1'b0;
                    w_state = S_IDLE;
                    w_tmo   = '0;
                end
            end

            S_READ: begin
                w_tmo   = r_tmo + c_TMO_W'(1);
                w_e_ovr = frame_valid;
                if (rd_ack) begin
                    w_rd_req     = 1'b0;
                    w_resp_data  = rd_data;
                    w_resp_valid = 1'b1;
                    w_state      = S_IDLE;
                    w_tmo        = '0;
                end else if (w_expire) begin
                    w_e_tmo  = 1'b1;
                    w_rd_req = 1'b0;
                    w_state  = S_IDLE;
                    w_tmo    = '0;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // One strobe per cycle: timeout > overrun > parity > range.
    assign w_err_any  = w_e_tmo | w_e_ovr | w_e_par | w_e_rng;
    assign w_err_code = w_e_tmo ? c_ERR_TIMEOUT :
                        w_e_ovr ? c_ERR_OVERRUN :
                        w_e_par ? c_ERR_PARITY  : c_ERR_RANGE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tmo        <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_oor        <= 1'b0;
            r_data       <= '0;
            r_wr_en      <= 1'b0;
            r_rd_req     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_err_pulse  <= 1'b0;
            r_err_code   <= 2'd0;
            r_err_count  <= 8'd0;
        end else begin
            r_state      <= w_state;
            r_tmo        <= w_tmo;
            r_cnt        <= w_cnt;
            r_addr       <= w_addr;
            r_oor        <= w_oor;
            r_data       <= w_data;
            r_wr_en      <= w_wr_en;
            r_rd_req     <= w_rd_req;
            r_resp_valid <= w_resp_valid;
            r_resp_data  <= w_resp_data;
            r_err_pulse  <= w_err_any;
            if (w_err_any) begin
                r_err_code <= w_err_code;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_addr;
    assign wr_data    = r_data;
    assign rd_req     = r_rd_req;
    assign rd_addr    = r_addr;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign err_pulse  = r_err_pulse;
    assign err_code   = r_err_code;
    assign err_count  = r_err_count;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_decoder
// Purpose  : Self-checking bench for uart_cmd_decoder (ADDR_W=4, DATA_W=8,
//            NUM_REGS=12, TIMEOUT=1000). Expected writes, read responses and
//            error codes are queued as stimulus is driven and popped when the
//            DUT produces the matching output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 12;
    localparam int TIMEOUT  = 1000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_valid = 1'b0;
    logic [8:0]        frame = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack = 1'b0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              err_pulse;
    logic [1:0]        err_code;
    logic [7:0]        err_count;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int exp_err_count = 0;

    wr_exp_t     wr_q[$];
    logic [7:0]  rd_q[$];
    logic [1:0]  er_q[$];

    uart_cmd_decoder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame       (frame),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Frame with correct even parity in bit 8.
    function automatic logic [8:0] mk(input logic [7:0] b);
        return {^b, b};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] f);
        frame       = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        frame       = '0;
    endtask

    // Pops the expected error and checks the strobe, code and count.
    task automatic check_error(input string name);
        logic [1:0] e;
        checks++;
        if (er_q.size() == 0) begin
            failures++;
            $display("FAIL %s_queue: error strobe %b with no expected error queued", name, err_pulse);
        end else begin
            e = er_q.pop_front();
            if (err_pulse !== 1'b1 || err_code !== e) begin
                failures++;
                $display("FAIL %s_err: got pulse=%b code=%0d expected pulse=1 code=%0d", name, err_pulse, err_code, e);
            end
        end
        checks++;
        if (err_count !== 8'(exp_err_count)) begin
            failures++;
            $display("FAIL %s_count: got %0d expected %0d", name, err_count, exp_err_count);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({wr_en, rd_req, resp_valid, err_pulse, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got wr_en=%b rd_req=%b resp_valid=%b err_pulse=%b busy=%b expected all 0",
                     wr_en, rd_req, resp_valid, err_pulse, busy);
        end
        checks++;
        if (resp_data !== '0 || err_code !== 2'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: got resp_data=%h err_code=%0d err_count=%0d expected 0/0/0",
                     resp_data, err_code, err_count);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write(input logic [6:0] addr, input logic [7:0] d, input int ack_delay);
        wr_exp_t e;
        int      hi;
        wr_q.push_back({addr[ADDR_W-1:0], d});
        send_frame(mk({1'b1, addr}));
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL write_hdr: got busy=%b wr_en=%b expected busy=1 wr_en=0", busy, wr_en);
        end
        send_frame(mk(d));
        checks++;
        if (wr_en !== 1'b1) begin
            failures++;
            $display("FAIL write_latency: got wr_en=%b expected 1", wr_en);
        end
        hi = 0;
        for (int i = 0; i < ack_delay; i++) begin
            if (wr_en) hi++;
            tick();
        end
        wr_ack = 1'b1;
        if (wr_en) hi++;
        e = wr_q.pop_front();
        checks++;
        if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL write_payload: got addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
        end
        tick();
        wr_ack = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || hi != ack_delay + 1) begin
            failures++;
            $display("FAIL write_hold: got wr_en=%b busy=%b high_cycles=%0d expected 0/0/%0d", wr_en, busy, hi, ack_delay + 1);
        end
    endtask

    task automatic test_read(input logic [6:0] addr, input logic [7:0] rv, input int ack_delay);
        logic [7:0] e;
        rd_q.push_back(rv);
        send_frame(mk({1'b0, addr}));
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== addr[ADDR_W-1:0]) begin
            failures++;
            $display("FAIL read_req: got rd_req=%b rd_addr=%0d expected 1/%0d", rd_req, rd_addr, addr);
        end
        for (int i = 0; i < ack_delay; i++) tick();
        rd_data = rv;
        rd_ack  = 1'b1;
        tick();
        rd_ack  = 1'b0;
        rd_data = 8'($urandom);
        e = rd_q.pop_front();
        checks++;
        if (rd_req !== 1'b0 || resp_valid !== 1'b1 || resp_data !== e) begin
            failures++;
            $display("FAIL read_resp: got rd_req=%b resp_valid=%b resp_data=%h expected 0/1/%h", rd_req, resp_valid, resp_data, e);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== e || busy !== 1'b0) begin
            failures++;
            $display("FAIL read_after: got resp_valid=%b resp_data=%h busy=%b expected 0/%h/0", resp_valid, resp_data, busy, e);
        end
    endtask

    task automatic test_range;
        int seen_wr;
        // Write to addr 14: data byte still consumed, then range error.
        send_frame(mk(8'h8E));
        checks++;
        if (busy !== 1'b1 || err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL range_wr_hdr: got busy=%b err_pulse=%b expected 1/0", busy, err_pulse);
        end
        er_q.push_back(2'd1);
        exp_err_count++;
        send_frame(mk(8'h11));
        check_error("range_wr");
        seen_wr = 0;
        for (int i = 0; i < 4; i++) begin
            if (wr_en) seen_wr++;
            tick();
        end
        checks++;
        if (seen_wr != 0 || busy !== 1'b0 || err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL range_wr_idle: got wr_en_cycles=%0d busy=%b err_pulse=%b expected 0/0/0", seen_wr, busy, err_pulse);
        end
        // Read of addr 12 (first invalid address): stay idle.
        er_q.push_back(2'd1);
        exp_err_count++;
        send_frame(mk(8'h0C));
        check_error("range_rd");
        checks++;
        if (rd_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL range_rd_idle: got rd_req=%b busy=%b expected 0/0", rd_req, busy);
        end
        // Addr 11 is the last valid address.
        test_read(7'd11, 8'h3C, 0);
    endtask

    task automatic test_timeout;
        int n;
        int seen_wr;
        send_frame(mk(8'h83));
        er_q.push_back(2'd2);
        exp_err_count++;
        n = 0;
        seen_wr = 0;
        for (int i = 1; i <= TIMEOUT + 200; i++) begin
            tick();
            if (wr_en) seen_wr++;
            if (err_pulse) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != TIMEOUT || seen_wr != 0) begin
            failures++;
            $display("FAIL timeout_cycles: got pulse after %0d cycles (0 = none) wr_en_cycles=%0d expected %0d/0", n, seen_wr, TIMEOUT);
        end
        check_error("timeout");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle: got busy=%b expected 0", busy);
        end
        test_read(7'd10, 8'h77, 1);
    endtask

    task automatic test_overrun;
        logic [7:0] e;
        rd_q.push_back(8'hA5);
        send_frame(mk(8'h05));
        er_q.push_back(2'd3);
        exp_err_count++;
        send_frame(mk(8'hFF));
        check_error("overrun");
        checks++;
        if (rd_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold: got rd_req=%b busy=%b expected 1/1", rd_req, busy);
        end
        rd_data = 8'hA5;
        rd_ack  = 1'b1;
        tick();
        rd_ack  = 1'b0;
        e = rd_q.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== e || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL overrun_resp: got resp_valid=%b resp_data=%h rd_req=%b expected 1/%h/0", resp_valid, resp_data, rd_req, e);
        end
        tick();
    endtask

    task automatic test_parity;
`ifdef UART_CMD_PARITY_CHECK_EN
        er_q.push_back(2'd0);
        exp_err_count++;
        send_frame(9'h083);
        check_error("parity_hdr");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL parity_idle: got busy=%b expected 0", busy);
        end
`else
        send_frame(9'h083);
        checks++;
        if (busy !== 1'b1 || err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL parity_ignored: got busy=%b err_pulse=%b expected 1/0", busy, err_pulse);
        end
        send_frame(mk(8'h5A));
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 8'h5A) begin
            failures++;
            $display("FAIL parity_write: got wr_en=%b addr=%0d data=%h expected 1/3/5a", wr_en, wr_addr, wr_data);
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
`endif
    endtask

    task automatic test_reset_mid;
        send_frame(mk(8'h83));
        send_frame(mk(8'h5A));
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_err_count = 0;
        checks++;
        if (wr_en !== 1'b0 || err_count !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got wr_en=%b err_count=%0d busy=%b expected 0/0/0", wr_en, err_count, busy);
        end
        test_write(7'd3, 8'h5A, 3);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            test_write(7'(k + 1), 8'($urandom), k);
            test_read(7'(k + 6), 8'($urandom), k);
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write(7'd3, 8'h5A, 3);
        test_read(7'd5, 8'hC3, 2);
        test_range();
        test_timeout();
        test_overrun();
        test_parity();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0 || er_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got wr=%0d rd=%0d err=%0d entries left expected 0", wr_q.size(), rd_q.size(), er_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
